// File: rtl/fp_round_pack.sv
// Normalize, round-to-nearest-even and pack into an IEEE-754 single behind a two-stage
// valid/ready pipeline. Define FP_ROUND_PACK_STICKY_STATUS_EN to add the sticky status register.
module fp_round_pack #(
   parameter int E_W    = 10,
   parameter int M_W    = 48,
   parameter int FRAC_W = 23
) (
   input  logic              clk,
   input  logic              arst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [E_W-1:0]    e_in,
   input  logic [M_W-1:0]    m_in,
   input  logic              s_in,
   input  logic              nan_in,
   input  logic              inf_in,
   input  logic              zero_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       result,
   output logic              ovf,
   output logic              unf,
   output logic              inx
`ifdef FP_ROUND_PACK_STICKY_STATUS_EN
   ,
   input  logic              flag_clr,
   output logic [2:0]        status
`endif
);

   typedef enum logic [2:0] {
      CLS_NUM,
      CLS_NAN,
      CLS_INF,
      CLS_ZERO,
      CLS_TINY
   } cls_e;

   typedef struct packed {
      logic              sign;
      cls_e              cls;
      logic [E_W:0]      exp;
      logic [FRAC_W-1:0] frac;
      logic              guard;
      logic              sticky;
   } s1_t;

   typedef struct packed {
      logic [31:0] res;
      logic        ovf;
      logic        unf;
      logic        inx;
   } s2_t;

   localparam logic [E_W:0] EXP_INF = (E_W+1)'(255);

   logic         s1_valid_d, s1_valid_q;
   logic         s2_valid_d, s2_valid_q;
   s1_t          s1_d, s1_q;
   s2_t          s2_d, s2_q;
   s1_t          norm;
   s2_t          pack;
   logic         s2_load, s1_adv, in_fire;
   logic [1:0]   shamt;
   logic [M_W-1:0] m_norm;
   logic         m_norm_unused;
   logic         rnd_inc;
   logic [FRAC_W:0] frac_rnd;
   logic [E_W:0] exp_rnd;

   // Normalize: shift the leading one to bit M_W-1 and compensate the exponent.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      shamt = 2'd0;
      if (m_in[M_W-1])      shamt = 2'd0;
      else if (m_in[M_W-2]) shamt = 2'd1;
      else if (m_in[M_W-3]) shamt = 2'd2;
      m_norm = m_in << shamt;

      norm.sign   = s_in;
      norm.exp    = {e_in[E_W-1], e_in} + (E_W+1)'(1) - (E_W+1)'(shamt);
      norm.frac   = m_norm[M_W-2 -: FRAC_W];
      norm.guard  = m_norm[M_W-2-FRAC_W];
      norm.sticky = |m_norm[M_W-3-FRAC_W:0];
      if (nan_in)                      norm.cls = CLS_NAN;
      else if (inf_in)                 norm.cls = CLS_INF;
      else if (zero_in)                norm.cls = CLS_ZERO;
      else if (m_in[M_W-1 -: 3] == '0) norm.cls = CLS_TINY;
      else                             norm.cls = CLS_NUM;
   end

   assign m_norm_unused = m_norm[M_W-1];

   // Round to nearest-even, then range-check the rounded exponent and pack.
   always_comb begin
      rnd_inc  = s1_q.guard & (s1_q.sticky | s1_q.frac[0]);
      frac_rnd = {1'b0, s1_q.frac} + (FRAC_W+1)'(rnd_inc);
      exp_rnd  = s1_q.exp + (E_W+1)'(frac_rnd[FRAC_W]);

      pack = '0;
      case (s1_q.cls)
         CLS_NAN:  pack.res = 32'h7FC0_0000;
         CLS_INF:  pack.res = {s1_q.sign, 8'hFF, {FRAC_W{1'b0}}};
         CLS_ZERO: pack.res = {s1_q.sign, 31'h0};
         CLS_TINY: begin
            pack.res = {s1_q.sign, 31'h0};
            pack.unf = 1'b1;
            pack.inx = 1'b1;
         end
         default: begin
            if ($signed(exp_rnd) >= $signed(EXP_INF)) begin
               pack.res = {s1_q.sign, 8'hFF, {FRAC_W{1'b0}}};
               pack.ovf = 1'b1;
               pack.inx = 1'b1;
            end else if ($signed(exp_rnd) <= $signed((E_W+1)'(0))) begin
               pack.res = {s1_q.sign, 31'h0};
               pack.unf = 1'b1;
               pack.inx = 1'b1;
            end else begin
               pack.res = {s1_q.sign, exp_rnd[7:0], frac_rnd[FRAC_W-1:0]};
               pack.inx = s1_q.guard | s1_q.sticky;
            end
         end
      endcase
   end

   assign s2_load  = ~s2_valid_q | out_ready;
   assign s1_adv   = s1_valid_q & s2_load;
   assign in_ready = ~s1_valid_q | s1_adv;
   assign in_fire  = in_valid & in_ready;

   always_comb begin
      s1_valid_d = s1_valid_q;
      s2_valid_d = s2_valid_q;
      s1_d       = s1_q;
      s2_d       = s2_q;
      if (in_ready) s1_valid_d = in_valid;
      if (in_fire)  s1_d       = norm;
      if (s2_load)  s2_valid_d = s1_valid_q;
      if (s1_adv)   s2_d       = pack;
   end

   always_ff @(posedge clk) begin
      if (arst) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
      end
   end

   // NOTE: payload registers carry no reset; the valid bits qualify them and gate the outputs.
   always_ff @(posedge clk) begin
      s1_q <= s1_d;
      s2_q <= s2_d;
   end

   assign out_valid = s2_valid_q;
   assign result    = s2_valid_q ? s2_q.res : 32'h0;
   assign ovf       = s2_valid_q & s2_q.ovf;
   assign unf       = s2_valid_q & s2_q.unf;
   assign inx       = s2_valid_q & s2_q.inx;

`ifdef FP_ROUND_PACK_STICKY_STATUS_EN
   logic [2:0] status_d, status_q;

   // Clear and set in the same cycle: the arriving flag survives.
   always_comb begin
      status_d = flag_clr ? 3'b000 : status_q;
      if (out_valid & out_ready) status_d = status_d | {ovf, unf, inx};
   end

   always_ff @(posedge clk) begin
      if (arst) status_q <= 3'b000;
      else      status_q <= status_d;
   end

   assign status = status_q;
`endif

endmodule

// File: tb/tb_fp_round_pack.sv
// Bench for fp_round_pack: table vectors flow through a scoreboard queue, plus hand
// sequences for backpressure with specials and reset of a full pipeline.
`timescale 1ns/1ps
module tb_fp_round_pack;

   logic        clk = 1'b0;
   logic        arst, in_valid, in_ready, s_in, nan_in, inf_in, zero_in;
   logic        out_valid, out_ready, ovf, unf, inx;
   logic [9:0]  e_in;
   logic [47:0] m_in;
   logic [31:0] result;
`ifdef FP_ROUND_PACK_STICKY_STATUS_EN
   logic        flag_clr;
   logic [2:0]  status;
`endif

   always #5 clk = ~clk;

   fp_round_pack dut (
      .clk       (clk),
      .arst      (arst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .e_in      (e_in),
      .m_in      (m_in),
      .s_in      (s_in),
      .nan_in    (nan_in),
      .inf_in    (inf_in),
      .zero_in   (zero_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .ovf       (ovf),
      .unf       (unf),
      .inx       (inx)
`ifdef FP_ROUND_PACK_STICKY_STATUS_EN
      ,
      .flag_clr  (flag_clr),
      .status    (status)
`endif
   );

   typedef struct {
      logic [9:0]  e;
      logic [47:0] m;
      logic        s, nan, inf, zero;
      logic [31:0] res;
      logic [2:0]  flg;   // {ovf, unf, inx}
   } vec_t;

   typedef struct packed {
      logic [31:0] res;
      logic [2:0]  flg;
   } exp_t;

   vec_t vecs[$];
   exp_t exp_q[$];
   exp_t cur_exp;
   exp_t mon_e;
   int   n_pass = 0;
   int   n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %08h, expected %08h", name, act, req);
   endtask

   task automatic add(input logic [9:0] e, input logic [47:0] m, input logic s,
                      input logic nan, input logic inf, input logic zero,
                      input logic [31:0] res, input logic [2:0] flg);
      vec_t v;
      v.e = e; v.m = m; v.s = s; v.nan = nan; v.inf = inf; v.zero = zero;
      v.res = res; v.flg = flg;
      vecs.push_back(v);
   endtask

   // Scoreboard: outputs pop before inputs push, both sampled away from the rising edge.
   always @(negedge clk) begin
      if (!arst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected output", {31'b0, out_valid}, 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("result", result, mon_e.res);
            check("flags", {29'b0, ovf, unf, inx}, {29'b0, mon_e.flg});
         end
      end
      if (!arst && in_valid && in_ready) exp_q.push_back(cur_exp);
   end

   // Entered and left at posedge+1; holds the word until the DUT takes it.
   task automatic send(input vec_t v, input bit rnd_ready);
      bit acc = 1'b0;
      int waited = 0;
      e_in = v.e; m_in = v.m; s_in = v.s;
      nan_in = v.nan; inf_in = v.inf; zero_in = v.zero;
      cur_exp = {v.res, v.flg};
      in_valid = 1'b1;
      while (!acc && waited < 50) begin
         if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         acc = in_ready;
         @(posedge clk); #1;
         waited++;
      end
      if (!acc) check("accept timeout", {31'b0, in_ready}, 32'd1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int waited = 0;
      out_ready = 1'b1;
      while (exp_q.size() != 0 && waited < 40) begin
         @(posedge clk); #1;
         waited++;
      end
      check("drain outstanding", exp_q.size(), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      arst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      e_in = '0; m_in = '0; s_in = 1'b0; nan_in = 1'b0; inf_in = 1'b0; zero_in = 1'b0;
      cur_exp = '0;
`ifdef FP_ROUND_PACK_STICKY_STATUS_EN
      flag_clr = 1'b0;
`endif
      add(10'd127, 48'h9000_0000_0000, 0, 0, 0, 0, 32'h4010_0000, 3'b000);
      add(10'd254, 48'h8000_0000_0000, 0, 0, 0, 0, 32'h7F80_0000, 3'b101);
      add(10'd254, 48'h8000_0000_0000, 1, 0, 0, 0, 32'hFF80_0000, 3'b101);
      add(10'h3FF, 48'h4000_0000_0000, 0, 0, 0, 0, 32'h0000_0000, 3'b011);
      add(10'd127, 48'h7FFF_FFFF_FFFF, 0, 0, 0, 0, 32'h4000_0000, 3'b001);
      add(10'd127, 48'h4000_0040_0000, 0, 0, 0, 0, 32'h3F80_0000, 3'b001);
      add(10'd127, 48'h4000_00C0_0000, 0, 0, 0, 0, 32'h3F80_0002, 3'b001);
      add(10'd127, 48'h4000_0060_0000, 0, 0, 0, 0, 32'h3F80_0001, 3'b001);
      add(10'd127, 48'h4000_0000_0001, 0, 0, 0, 0, 32'h3F80_0000, 3'b001);
      add(10'd128, 48'hC000_0080_0000, 0, 0, 0, 0, 32'h40C0_0000, 3'b001);
      add(10'd127, 48'h2000_0000_0000, 0, 0, 0, 0, 32'h3F00_0000, 3'b000);
      add(10'd1,   48'h2000_0000_0000, 1, 0, 0, 0, 32'h8000_0000, 3'b011);
      add(10'd1,   48'h4000_0000_0000, 0, 0, 0, 0, 32'h0080_0000, 3'b000);
      add(10'd254, 48'h4000_0000_0000, 0, 0, 0, 0, 32'h7F00_0000, 3'b000);
      add(10'd253, 48'hFFFF_FFFF_FFFF, 0, 0, 0, 0, 32'h7F80_0000, 3'b101);
      add(10'h3FE, 48'h8000_0000_0000, 0, 0, 0, 0, 32'h0000_0000, 3'b011);
      add(10'h1FF, 48'h8000_0000_0000, 0, 0, 0, 0, 32'h7F80_0000, 3'b101);
      add(10'h200, 48'h8000_0000_0000, 1, 0, 0, 0, 32'h8000_0000, 3'b011);
      add(10'd127, 48'h0000_0000_0001, 1, 0, 0, 0, 32'h8000_0000, 3'b011);
      add(10'd0,   48'h0000_0000_0000, 1, 1, 1, 0, 32'h7FC0_0000, 3'b000);
      add(10'd0,   48'h0000_0000_0000, 0, 0, 1, 1, 32'h7F80_0000, 3'b000);
      add(10'd254, 48'h8000_0000_0000, 1, 0, 0, 1, 32'h8000_0000, 3'b000);

      repeat (2) @(posedge clk);
      #1 arst = 1'b0;
      @(negedge clk);
      check("reset out_valid", {31'b0, out_valid}, 32'd0);
      check("reset in_ready", {31'b0, in_ready}, 32'd1);
      check("reset result", result, 32'h0);
      check("reset flags", {29'b0, ovf, unf, inx}, 32'd0);
      @(posedge clk); #1;

      out_ready = 1'b1;
      foreach (vecs[i]) send(vecs[i], 1'b0);
      drain();
      foreach (vecs[i]) send(vecs[i], 1'b1);
      drain();

      // Backpressure: NaN, -Inf, zero back to back with the consumer stalled.
      out_ready = 1'b0;
      send(vecs[19], 1'b0);
      vecs[20].s = 1'b1; vecs[20].zero = 1'b0; vecs[20].res = 32'hFF80_0000;
      send(vecs[20], 1'b0);
      e_in = '0; m_in = '0; s_in = 1'b0; nan_in = 1'b0; inf_in = 1'b0; zero_in = 1'b1;
      cur_exp = {32'h0000_0000, 3'b000};
      in_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("stall in_ready", {31'b0, in_ready}, 32'd0);
         check("stall out_valid", {31'b0, out_valid}, 32'd1);
         check("stall result", result, 32'h7FC0_0000);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("release in_ready", {31'b0, in_ready}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0; zero_in = 1'b0;
      drain();

      // Full pipeline discarded by reset; the next word travels alone.
      out_ready = 1'b0;
      send(vecs[0], 1'b0);
      send(vecs[5], 1'b0);
      arst = 1'b1;
      exp_q.delete();
      @(posedge clk); #1;
      arst = 1'b0;
      @(negedge clk);
      check("flush out_valid", {31'b0, out_valid}, 32'd0);
      check("flush in_ready", {31'b0, in_ready}, 32'd1);
      check("flush result", result, 32'h0);
      check("flush flags", {29'b0, ovf, unf, inx}, 32'd0);
      @(posedge clk); #1;
      out_ready = 1'b1;
      e_in = vecs[1].e; m_in = vecs[1].m; s_in = vecs[1].s;
      nan_in = 1'b0; inf_in = 1'b0; zero_in = 1'b0;
      cur_exp = {vecs[1].res, vecs[1].flg};
      in_valid = 1'b1;
      @(negedge clk);
      check("lat c0 out_valid", {31'b0, out_valid}, 32'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      check("lat c1 out_valid", {31'b0, out_valid}, 32'd0);
      @(negedge clk);
      check("lat c2 out_valid", {31'b0, out_valid}, 32'd1);
      check("lat c2 result", result, 32'h7F80_0000);
      @(negedge clk);
      check("lat c3 out_valid", {31'b0, out_valid}, 32'd0);
      check("post-flush queue", exp_q.size(), 32'd0);

`ifdef FP_ROUND_PACK_STICKY_STATUS_EN
      check("status sticky", {29'b0, status}, 32'd5);
      @(posedge clk); #1;
      flag_clr = 1'b1;
      @(posedge clk); #1;
      flag_clr = 1'b0;
      @(negedge clk);
      check("status cleared", {29'b0, status}, 32'd0);
`endif

      @(posedge clk); #1;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
